// File: rtl/hdmi_pkg.sv
// Shared constants and encodings for the 640x480@60 pattern controller.
// Timing values describe the raster the pixel counters walk through.
package hdmi_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FPORCH = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BPORCH = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH;  // 800

  localparam int V_ACTIVE = 480;
  localparam int V_FPORCH = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BPORCH = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FPORCH + V_SYNC + V_BPORCH;  // 525

  localparam int BAR_WIDTH = H_ACTIVE / 8;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_WHITE = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ARMED = 2'd1,
    ST_MUTE  = 2'd2
  } state_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_BARS:  return MODE_WHITE;
      MODE_WHITE: return MODE_GRAD;
      default:    return MODE_BARS;
    endcase
  endfunction

  // Bar index by comparing against 80, 160, ... 560 instead of dividing.
  function automatic logic [2:0] bar_index(input logic [9:0] x);
    logic [2:0] b;
    b = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 10'(i * BAR_WIDTH)) b = 3'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer and stability debouncer; emits a one-cycle pulse
// when the accepted level falls from released (1) to pressed (0).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 252000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      press  <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // Accepting a new level while released means the button went down.
        level_q <= sync_q[1];
        cnt_q   <= '0;
        press   <= level_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdmi_pattern_ctrl.sv
// Test-pattern selector between the timing generator and TMDS encoders:
// frame-aligned pattern switching with a black mute interval after each switch.
module hdmi_pattern_ctrl
  import hdmi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 252000,
  parameter int MUTE_FRAMES     = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       btn,
  input  logic [9:0] cnt_x,
  input  logic [9:0] cnt_y,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       frame_start,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [1:0] mode,
  output logic       busy
);

  localparam logic [3:0] MUTE_LOAD = 4'(MUTE_FRAMES - 1);

  logic        press;
  state_t      state_q, state_d;
  mode_t       mode_q, mode_d;
  logic [3:0]  frm_cnt_q, frm_cnt_d;
  logic [2:0]  bar;
  logic [23:0] pix_d;
  logic        unused_cnt_y;

  assign unused_cnt_y = ^cnt_y[9:8];
  assign mode         = mode_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .btn   (btn),
    .press (press)
  );

  // NOTE: every signal gets a default first so no path through the block
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    frm_cnt_d = frm_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (press) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (frame_start) begin
          state_d   = ST_MUTE;
          mode_d    = next_mode(mode_q);
          frm_cnt_d = MUTE_LOAD;
        end
      end
      ST_MUTE: begin
        if (frame_start) begin
          if (frm_cnt_q == 4'd0) state_d = ST_RUN;
          else frm_cnt_d = frm_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Pixel uses next-state values so the switching frame's first pixel is black.
  assign bar = bar_index(cnt_x);

  always_comb begin
    pix_d = '0;
    if (de_in && (state_d != ST_MUTE)) begin
      case (mode_d)
        MODE_BARS:  pix_d = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
        MODE_WHITE: pix_d = 24'hFF_FF_FF;
        MODE_GRAD:  pix_d = {cnt_x[7:0], cnt_y[7:0], cnt_x[7:0] ^ cnt_y[7:0]};
        default:    pix_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_RUN;
      mode_q    <= MODE_BARS;
      frm_cnt_q <= '0;
      busy      <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      frm_cnt_q <= frm_cnt_d;
      busy      <= (state_d != ST_RUN);
      red       <= pix_d[23:16];
      green     <= pix_d[15:8];
      blue      <= pix_d[7:0];
      de_out    <= de_in;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

endmodule

// File: tb/tb_hdmi_pattern_ctrl.sv
// Scoreboard bench for hdmi_pattern_ctrl: directed pixel vectors push expected
// outputs; a monitor pops one entry per clock and compares.
module tb_hdmi_pattern_ctrl;

  localparam int DB = 8;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       btn = 1'b1;
  logic [9:0] cnt_x = '0;
  logic [9:0] cnt_y = '0;
  logic       de_in = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] red, green, blue;
  logic       de_out, hsync_out, vsync_out;
  logic [1:0] mode;
  logic       busy;

  hdmi_pattern_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .MUTE_FRAMES    (1)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .btn        (btn),
    .cnt_x      (cnt_x),
    .cnt_y      (cnt_y),
    .de_in      (de_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .frame_start(frame_start),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .de_out     (de_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .mode       (mode),
    .busy       (busy)
  );

  always #20 clk_in = ~clk_in;

  typedef struct {
    logic [23:0] rgb;
    logic [2:0]  sync;
    logic [1:0]  mode;
    logic        busy;
    string       tag;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_pass = 0;
  logic [1:0] exp_mode = 2'd0;
  logic  exp_busy = 1'b0;
  logic  exp_mute = 1'b0;
  logic  exp_rst = 1'b1;
  string cur_tag = "reset";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [23:0] pat(input logic [1:0] m, input int x, input int y);
    logic [7:0] xl, yl;
    logic [2:0] b;
    xl = 8'(x);
    yl = 8'(y);
    b  = 3'(x / 80);
    case (m)
      2'd0:    return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
      2'd1:    return 24'hFFFFFF;
      2'd2:    return {xl, yl, xl ^ yl};
      default: return 24'h000000;
    endcase
  endfunction

  // One pixel clock of stimulus; exp_* describe the state after the coming edge.
  task automatic px(input int x, input int y, input int de, input int hs,
                    input int vs, input int fs, input int b);
    exp_t e;
    @(negedge clk_in);
    cnt_x       = 10'(x);
    cnt_y       = 10'(y);
    de_in       = (de != 0);
    hsync_in    = (hs != 0);
    vsync_in    = (vs != 0);
    frame_start = (fs != 0);
    btn         = (b != 0);
    e.rgb  = (exp_rst || de == 0 || exp_mute) ? 24'h0 : pat(exp_mode, x, y);
    e.sync = exp_rst ? 3'b000 : {de_in, hsync_in, vsync_in};
    e.mode = exp_rst ? 2'd0 : exp_mode;
    e.busy = exp_rst ? 1'b0 : exp_busy;
    e.tag  = cur_tag;
    sb.push_back(e);
  endtask

  // 32 cycles with btn low for the first low_len; optional frame_start at fs_at.
  task automatic press_seq(input int low_len, input int fs_at, input int busy_from);
    for (int i = 1; i <= 32; i++) begin
      if (i == busy_from) exp_busy = 1'b1;
      if (i == fs_at) px(0, 0, 1, 0, 0, 1, (i <= low_len) ? 0 : 1);
      else px(200 + i, 100, 1, 0, 0, 0, (i <= low_len) ? 0 : 1);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.tag, ".rgb"}, 32'({red, green, blue}), 32'(e.rgb));
        check({e.tag, ".de_hs_vs"}, 32'({de_out, hsync_out, vsync_out}), 32'(e.sync));
        check({e.tag, ".mode"}, 32'(mode), 32'(e.mode));
        check({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    repeat (3) px(80, 5, 1, 1, 1, 0, 1);
    @(negedge clk_in);
    rst_in  = 1'b0;
    exp_rst = 1'b0;

    cur_tag = "bars";
    px(0, 0, 1, 0, 0, 1, 1);
    px(80, 0, 1, 0, 0, 0, 1);
    px(160, 0, 1, 0, 0, 0, 1);
    px(79, 1, 1, 0, 0, 0, 1);
    px(559, 1, 1, 0, 0, 0, 1);
    px(560, 1, 1, 0, 0, 0, 1);
    px(639, 1, 1, 0, 0, 0, 1);
    px(700, 1, 0, 1, 0, 0, 1);

    cur_tag = "glitch";
    press_seq(5, 0, 0);
    cur_tag = "press";
    press_seq(20, 0, 11);
    cur_tag = "press_armed";
    press_seq(20, 0, 0);

    cur_tag  = "switch";
    exp_mode = 2'd1;
    exp_mute = 1'b1;
    px(0, 0, 1, 0, 0, 1, 1);
    px(100, 10, 1, 0, 0, 0, 1);
    cur_tag = "press_mute";
    press_seq(20, 0, 0);

    cur_tag  = "white";
    exp_mute = 1'b0;
    exp_busy = 1'b0;
    px(0, 0, 1, 0, 0, 1, 1);
    px(400, 200, 1, 0, 0, 0, 1);
    px(639, 479, 1, 0, 0, 0, 1);

    cur_tag = "simul";
    press_seq(20, 11, 11);
    cur_tag  = "simul_switch";
    exp_mode = 2'd2;
    exp_mute = 1'b1;
    px(0, 0, 1, 0, 0, 1, 1);
    px(300, 50, 1, 0, 0, 0, 1);

    cur_tag  = "grad";
    exp_mute = 1'b0;
    exp_busy = 1'b0;
    px(0, 0, 1, 0, 0, 1, 1);
    px(10'h1A5, 10'h03C, 1, 0, 0, 0, 1);
    px(5, 7, 1, 0, 0, 0, 1);

    cur_tag = "wrap";
    press_seq(20, 0, 11);
    exp_mode = 2'd0;
    exp_mute = 1'b1;
    px(0, 0, 1, 0, 0, 1, 1);
    exp_mute = 1'b0;
    exp_busy = 1'b0;
    px(0, 0, 1, 0, 0, 1, 1);
    px(80, 0, 1, 0, 0, 0, 1);

    cur_tag = "align";
    for (int i = 0; i < 40; i++) begin
      px(int'($urandom_range(0, 639)), int'($urandom_range(1, 524)),
         int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
         int'($urandom_range(0, 1)), 0, 1);
    end

    cur_tag = "pre_reset";
    press_seq(20, 0, 11);
    exp_mode = 2'd1;
    exp_mute = 1'b1;
    px(0, 0, 1, 0, 0, 1, 1);
    exp_mute = 1'b0;
    exp_busy = 1'b0;
    px(0, 0, 1, 0, 0, 1, 1);
    press_seq(20, 0, 11);
    px(300, 100, 1, 1, 1, 0, 1);

    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_reset.rgb", 32'({red, green, blue}), 32'h0);
    check("async_reset.de_hs_vs", 32'({de_out, hsync_out, vsync_out}), 32'h0);
    check("async_reset.mode", 32'(mode), 32'h0);
    check("async_reset.busy", 32'(busy), 32'h0);

    cur_tag  = "in_reset";
    exp_rst  = 1'b1;
    exp_mode = 2'd0;
    exp_busy = 1'b0;
    repeat (2) px(300, 100, 1, 1, 1, 0, 1);
    @(negedge clk_in);
    rst_in  = 1'b0;
    exp_rst = 1'b0;

    cur_tag = "after_reset";
    px(0, 0, 1, 0, 0, 1, 1);
    px(80, 0, 1, 0, 0, 0, 1);

    repeat (3) @(posedge clk_in);
    #2;
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
